// File: rtl/vc_arbiter.sv
// Weighted round-robin arbiter/router: pops one word at a time from VC0/VC1,
// routes it on one header bit, and pushes it into D0/D1 under almost_full back-pressure.
module vc_arbiter #(
   parameter int DATA_W    = 12,
   parameter int ROUTE_BIT = 11,
   parameter int W0        = 4,
   parameter int W1        = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] vc0_data,
   input  logic              vc0_empty,
   output logic              vc0_pop,
   input  logic [DATA_W-1:0] vc1_data,
   input  logic              vc1_empty,
   output logic              vc1_pop,
   input  logic              d0_almost_full,
   output logic              d0_push,
   output logic [DATA_W-1:0] d0_data,
   input  logic              d1_almost_full,
   output logic              d1_push,
   output logic [DATA_W-1:0] d1_data,
   output logic              grant,
   output logic              idle,
   output logic [7:0]        d0_count,
   output logic [7:0]        d1_count
);

   typedef enum logic [1:0] {S_IDLE, S_POP, S_CAPTURE, S_PUSH} state_t;

   localparam logic [3:0] W0_C = 4'(W0);
   localparam logic [3:0] W1_C = 4'(W1);

   state_t            state, state_nx;
   logic              cur, cur_nx;
   logic [3:0]        credit, credit_nx;
   logic [DATA_W-1:0] hold, hold_nx;
   logic              dest, dest_nx;

   logic              grant_nx, idle_nx;
   logic              vc0_pop_nx, vc1_pop_nx;
   logic              d0_push_nx, d1_push_nx;
   logic [DATA_W-1:0] d0_data_nx, d1_data_nx;
   logic [7:0]        d0_count_nx, d1_count_nx;

   logic [3:0]        w_cur;
   logic              pick;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed by the combinational block.
   // NOTE: the hold/data registers are reset too, so an in-flight word is
   // discarded and the data outputs read 0 after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         cur      <= 1'b0;
         credit   <= 4'd0;
         hold     <= '0;
         dest     <= 1'b0;
         grant    <= 1'b0;
         idle     <= 1'b1;
         vc0_pop  <= 1'b0;
         vc1_pop  <= 1'b0;
         d0_push  <= 1'b0;
         d1_push  <= 1'b0;
         d0_data  <= '0;
         d1_data  <= '0;
         d0_count <= 8'd0;
         d1_count <= 8'd0;
      end else begin
         state    <= state_nx;
         cur      <= cur_nx;
         credit   <= credit_nx;
         hold     <= hold_nx;
         dest     <= dest_nx;
         grant    <= grant_nx;
         idle     <= idle_nx;
         vc0_pop  <= vc0_pop_nx;
         vc1_pop  <= vc1_pop_nx;
         d0_push  <= d0_push_nx;
         d1_push  <= d1_push_nx;
         d0_data  <= d0_data_nx;
         d1_data  <= d1_data_nx;
         d0_count <= d0_count_nx;
         d1_count <= d1_count_nx;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nx    = state;
      cur_nx      = cur;
      credit_nx   = credit;
      hold_nx     = hold;
      dest_nx     = dest;
      grant_nx    = grant;
      vc0_pop_nx  = 1'b0;
      vc1_pop_nx  = 1'b0;
      d0_push_nx  = 1'b0;
      d1_push_nx  = 1'b0;
      d0_data_nx  = d0_data;
      d1_data_nx  = d1_data;
      d0_count_nx = d0_count;
      d1_count_nx = d1_count;
      w_cur       = cur ? W1_C : W0_C;
      pick        = 1'b0;

      case (state)
         S_IDLE: begin
            if (!vc0_empty && !vc1_empty) begin
               // Both waiting: stay on cur until its weight is used up.
               if (credit < w_cur) begin
                  pick      = cur;
                  credit_nx = credit + 4'd1;
               end else begin
                  pick      = ~cur;
                  cur_nx    = ~cur;
                  credit_nx = 4'd1;
               end
            end else if (!vc0_empty || !vc1_empty) begin
               pick = vc0_empty;
               if (pick == cur) begin
                  credit_nx = (credit < w_cur) ? credit + 4'd1 : w_cur;
               end else begin
                  cur_nx    = pick;
                  credit_nx = 4'd1;
               end
            end

            if (!vc0_empty || !vc1_empty) begin
               grant_nx   = pick;
               vc0_pop_nx = ~pick;
               vc1_pop_nx = pick;
               state_nx   = S_POP;
            end
         end

         S_POP: begin
            state_nx = S_CAPTURE;
         end

         S_CAPTURE: begin
            hold_nx  = grant ? vc1_data : vc0_data;
            dest_nx  = hold_nx[ROUTE_BIT];
            state_nx = S_PUSH;
         end

         S_PUSH: begin
            // Only the selected destination's almost_full can stall the word.
            if (!dest && !d0_almost_full) begin
               d0_push_nx  = 1'b1;
               d0_data_nx  = hold;
               d0_count_nx = d0_count + 8'd1;
               state_nx    = S_IDLE;
            end else if (dest && !d1_almost_full) begin
               d1_push_nx  = 1'b1;
               d1_data_nx  = hold;
               d1_count_nx = d1_count + 8'd1;
               state_nx    = S_IDLE;
            end
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase

      idle_nx = (state_nx == S_IDLE);
   end

endmodule
